// File: rtl/loop_control_unit_pkg.sv
// Shared types for the BeeF loop control unit: FSM states, error codes and the
// program-counter type used by fetch and the loop LIFO.
package loop_control_unit_pkg;

  localparam int PROGRAM_COUNTER_W = 16;
  typedef logic [PROGRAM_COUNTER_W-1:0] program_counter_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    ERROR = 2'd2
  } loop_state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    OVF  = 2'b01,
    UNF  = 2'b10,
    NEST = 2'b11
  } loop_err_e;

  function automatic int occupancy_w(input int entries);
    return $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/loop_control_unit_if.sv
// Instruction-side bus between the core and the loop control unit, plus the
// unit's redirect, status and debug outputs.
interface loop_control_unit_if
  import loop_control_unit_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DEPTH  = 16,
  parameter int NEST_W = 8
) ();

  localparam int CW = occupancy_w(DEPTH);

  // No valid/ready: exactly one instruction is presented every cycle. is_open,
  // is_close, acc_zero and pc describe it; pc_load/pc_target answer in the same
  // cycle, and all register updates land on the following rising clk edge.
  logic              flush;
  logic              is_open;
  logic              is_close;
  logic              acc_zero;
  logic [PC_W-1:0]   pc;

  logic              pc_load;
  logic [PC_W-1:0]   pc_target;
  logic              skip_active;
  logic [CW-1:0]     depth;
  logic              err;
  logic [1:0]        err_code;

  loop_state_e       state;
  logic [NEST_W-1:0] nest;

  modport master (
    output flush, is_open, is_close, acc_zero, pc,
    input  pc_load, pc_target, skip_active, depth, err, err_code, state, nest
  );

  modport slave (
    input  flush, is_open, is_close, acc_zero, pc,
    output pc_load, pc_target, skip_active, depth, err, err_code, state, nest
  );

endinterface

// File: rtl/loop_control_unit_pc_lifo.sv
// LIFO of loop-entry program counters: synchronous push/pop/clear, combinational
// top-of-stack read, full/empty flags and occupancy count.
module pc_lifo
  import loop_control_unit_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            push_data,
  output logic [PC_W-1:0]            top,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] mem [DEPTH];
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   top_idx;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear && !push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (do_push) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (do_pop) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[cnt_q[AW-1:0]] <= push_data;
    end
  end

  // Low bits only: when full the count's low bits are zero and wrap to DEPTH-1.
  assign top_idx = cnt_q[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;

endmodule

// File: rtl/loop_control_unit.sv
// Bracket engine: pushes loop-entry PCs on '[', redirects fetch on a taken ']',
// and skips untaken loop bodies by counting bracket nesting. Errors freeze the unit.
module loop_control_unit
  import loop_control_unit_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DEPTH  = 16,
  parameter int NEST_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  loop_control_unit_if.slave  bus
);

  localparam int CW = occupancy_w(DEPTH);

  loop_state_e       state_q, state_n;
  logic [NEST_W-1:0] nest_q,  nest_n;
  loop_err_e         code_q,  code_n;

  logic              lifo_clear;
  logic              lifo_push;
  logic              lifo_pop;
  logic [PC_W-1:0]   lifo_top;
  logic              lifo_full;
  logic              lifo_empty;
  logic [CW-1:0]     lifo_count;
  logic              pc_load;

  pc_lifo #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (lifo_clear),
    .push      (lifo_push),
    .pop       (lifo_pop),
    .push_data (bus.pc),
    .top       (lifo_top),
    .full      (lifo_full),
    .empty     (lifo_empty),
    .count     (lifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      nest_q  <= '0;
      code_q  <= NONE;
    end else begin
      state_q <= state_n;
      nest_q  <= nest_n;
      code_q  <= code_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    nest_n     = nest_q;
    code_n     = code_q;
    lifo_clear = 1'b0;
    lifo_push  = 1'b0;
    lifo_pop   = 1'b0;
    pc_load    = 1'b0;

    if (bus.flush) begin
      lifo_clear = 1'b1;
      state_n    = IDLE;
      nest_n     = '0;
      code_n     = NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.is_open && bus.is_close) begin
            state_n = ERROR;
            code_n  = NEST;
          end else if (bus.is_open) begin
            if (bus.acc_zero) begin
              nest_n  = NEST_W'(1);
              state_n = SKIP;
            end else if (lifo_full) begin
              state_n = ERROR;
              code_n  = OVF;
            end else begin
              lifo_push = 1'b1;
            end
          end else if (bus.is_close) begin
            if (lifo_empty) begin
              state_n = ERROR;
              code_n  = UNF;
            end else if (bus.acc_zero) begin
              lifo_pop = 1'b1;
            end else begin
              pc_load = 1'b1;
            end
          end
        end

        SKIP: begin
          if (bus.is_open && bus.is_close) begin
            state_n = ERROR;
            code_n  = NEST;
          end else if (bus.is_open) begin
            if (nest_q == {NEST_W{1'b1}}) begin
              state_n = ERROR;
              code_n  = NEST;
            end else begin
              nest_n = nest_q + NEST_W'(1);
            end
          end else if (bus.is_close) begin
            // The matching ']' is consumed as a no-op; execution resumes after it.
            if (nest_q <= NEST_W'(1)) begin
              nest_n  = '0;
              state_n = IDLE;
            end else begin
              nest_n = nest_q - NEST_W'(1);
            end
          end
        end

        ERROR: begin
          state_n = ERROR;
        end

        default: begin
          state_n = ERROR;
          code_n  = NEST;
        end
      endcase
    end
  end

  assign bus.pc_load     = pc_load;
  assign bus.pc_target   = lifo_top + PC_W'(1);
  assign bus.skip_active = (state_q == SKIP);
  assign bus.depth       = lifo_count;
  assign bus.err         = (state_q == ERROR);
  assign bus.err_code    = code_q;
  assign bus.state       = state_q;
  assign bus.nest        = nest_q;

  a_depth_bounded: assert property (@(posedge clk) disable iff (reset)
    lifo_count <= CW'(DEPTH));
  a_redirect_only_idle: assert property (@(posedge clk) disable iff (reset)
    pc_load |-> (state_q == IDLE));
  a_err_code_set: assert property (@(posedge clk) disable iff (reset)
    (state_q == ERROR) |-> (code_q != NONE));

endmodule

// File: tb/tb_loop_control_unit.sv
// Directed bench for loop_control_unit (DEPTH=4, NEST_W=2) with hand-computed
// expected values for push/redirect/pop, skip nesting, errors, flush and async reset.
module tb_loop_control_unit;
  import loop_control_unit_pkg::*;

  localparam int PC_W   = 16;
  localparam int DEPTH  = 4;
  localparam int NEST_W = 2;

  logic clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  loop_control_unit_if #(.PC_W(PC_W), .DEPTH(DEPTH), .NEST_W(NEST_W)) bus ();

  loop_control_unit #(
    .PC_W   (PC_W),
    .DEPTH  (DEPTH),
    .NEST_W (NEST_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic drive(input logic o, input logic c, input logic z, input logic [PC_W-1:0] p);
    bus.is_open  = o;
    bus.is_close = c;
    bus.acc_zero = z;
    bus.pc       = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    check("rst_depth", 32'(bus.depth), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_code", 32'(bus.err_code), 0);
    check("rst_pc_load", 32'(bus.pc_load), 0);
    check("rst_skip", 32'(bus.skip_active), 0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    tick();
    reset = 1'b0;

    // 1: '[' at 5 taken, ']' at 9 taken -> redirect to 6
    drive(1'b1, 1'b0, 1'b0, 16'd5);
    tick();
    check("t1_depth_push", 32'(bus.depth), 1);
    drive(1'b0, 1'b1, 1'b0, 16'd9);
    #1;
    check("t1_pc_load", 32'(bus.pc_load), 1);
    check("t1_pc_target", 32'(bus.pc_target), 6);
    tick();
    check("t1_depth_kept", 32'(bus.depth), 1);

    // 2: ']' with acc_zero -> pop, no redirect
    drive(1'b0, 1'b1, 1'b1, 16'd9);
    #1;
    check("t2_pc_load", 32'(bus.pc_load), 0);
    tick();
    check("t2_depth_pop", 32'(bus.depth), 0);
    check("t2_err", 32'(bus.err), 0);

    // 3: untaken '[' at 2 over body "[ ] ]"
    drive(1'b1, 1'b0, 1'b1, 16'd2);
    #1;
    check("t3_skip_before", 32'(bus.skip_active), 0);
    tick();
    check("t3_skip_c1", 32'(bus.skip_active), 1);
    check("t3_nest_c1", 32'(bus.nest), 1);
    check("t3_state_c1", 32'(bus.state), 32'(SKIP));
    drive(1'b1, 1'b0, 1'b0, 16'd3);
    tick();
    check("t3_skip_c2", 32'(bus.skip_active), 1);
    check("t3_nest_c2", 32'(bus.nest), 2);
    drive(1'b0, 1'b1, 1'b0, 16'd4);
    #1;
    check("t3_no_redirect", 32'(bus.pc_load), 0);
    tick();
    check("t3_skip_c3", 32'(bus.skip_active), 1);
    check("t3_nest_c3", 32'(bus.nest), 1);
    drive(1'b0, 1'b1, 1'b0, 16'd5);
    tick();
    check("t3_nest_end", 32'(bus.nest), 0);
    check("t3_state_end", 32'(bus.state), 32'(IDLE));
    check("t3_skip_end", 32'(bus.skip_active), 0);
    check("t3_depth_end", 32'(bus.depth), 0);

    // 4: overflow at DEPTH=4, then flush (flush beats a same-cycle push)
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, PC_W'(10 + i));
      tick();
    end
    check("t4_depth_full", 32'(bus.depth), 4);
    check("t4_err_before", 32'(bus.err), 0);
    drive(1'b1, 1'b0, 1'b0, 16'd20);
    tick();
    check("t4_err", 32'(bus.err), 1);
    check("t4_code", 32'(bus.err_code), 32'(OVF));
    check("t4_depth_stays", 32'(bus.depth), 4);
    drive(1'b0, 1'b1, 1'b0, 16'd21);
    #1;
    check("t4_frozen_pc_load", 32'(bus.pc_load), 0);
    tick();
    check("t4_frozen_depth", 32'(bus.depth), 4);
    bus.flush = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'd22);
    tick();
    bus.flush = 1'b0;
    check("t4_flush_depth", 32'(bus.depth), 0);
    check("t4_flush_err", 32'(bus.err), 0);
    check("t4_flush_code", 32'(bus.err_code), 0);
    check("t4_flush_state", 32'(bus.state), 32'(IDLE));

    // pc_target wraps modulo 2^PC_W
    drive(1'b1, 1'b0, 1'b0, 16'hFFFF);
    tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0003);
    #1;
    check("wrap_pc_load", 32'(bus.pc_load), 1);
    check("wrap_pc_target", 32'(bus.pc_target), 0);
    drive(1'b0, 1'b1, 1'b1, 16'h0003);
    tick();
    check("wrap_depth_pop", 32'(bus.depth), 0);

    // 5: underflow, then simultaneous '[' and ']'
    drive(1'b0, 1'b1, 1'b1, 16'd30);
    #1;
    check("t5_unf_pc_load", 32'(bus.pc_load), 0);
    tick();
    check("t5_unf_err", 32'(bus.err), 1);
    check("t5_unf_code", 32'(bus.err_code), 32'(UNF));
    check("t5_unf_depth", 32'(bus.depth), 0);
    do_flush();
    drive(1'b1, 1'b1, 1'b0, 16'd31);
    tick();
    check("t5_both_err", 32'(bus.err), 1);
    check("t5_both_code", 32'(bus.err_code), 32'(NEST));
    check("t5_both_depth", 32'(bus.depth), 0);
    do_flush();

    // nest counter overflow at all-ones (NEST_W=2 -> 3)
    drive(1'b1, 1'b0, 1'b1, 16'd40);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'd41);
    tick();
    tick();
    check("nest_at_max", 32'(bus.nest), 3);
    check("nest_no_err_yet", 32'(bus.err), 0);
    tick();
    check("nest_ovf_err", 32'(bus.err), 1);
    check("nest_ovf_code", 32'(bus.err_code), 32'(NEST));
    check("nest_ovf_skip", 32'(bus.skip_active), 0);
    do_flush();

    // 6: asynchronous reset mid-SKIP
    drive(1'b1, 1'b0, 1'b0, 16'd49);
    tick();
    drive(1'b1, 1'b0, 1'b1, 16'd50);
    tick();
    check("t6_skip_on", 32'(bus.skip_active), 1);
    check("t6_depth_pre", 32'(bus.depth), 1);
    drive(1'b0, 1'b0, 1'b0, 16'd51);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_skip", 32'(bus.skip_active), 0);
    check("t6_async_depth", 32'(bus.depth), 0);
    check("t6_async_state", 32'(bus.state), 32'(IDLE));
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'd60);
    tick();
    check("t6_post_push", 32'(bus.depth), 1);
    drive(1'b0, 1'b1, 1'b0, 16'd61);
    #1;
    check("t6_post_target", 32'(bus.pc_target), 61);
    check("t6_post_load", 32'(bus.pc_load), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
